// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an external PWM waveform: high time and rise-to-rise period in clk
//   cycles, an 8-bit duty value, and flags for a stuck line (no edge for
//   TIMEOUT cycles) and an off-nominal period (outside PERIOD +/- TOL).
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      asynchronous, active-high reset
//   enable      in   1      1 = measure; 0 = re-arm, hold outputs
//   pwm_in      in   1      asynchronous PWM input
//   duty_cycle  out  8      last measured duty, min(high time, 255)
//   high_cnt    out  CNT_W  last measured high time in cycles
//   period_cnt  out  CNT_W  last measured period (rise to rise) in cycles
//   valid       out  1      one-cycle pulse when the outputs above update
//   stuck       out  1      line static for >= TIMEOUT cycles
//   period_err  out  1      last period outside PERIOD +/- TOL
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int PERIOD  = 256,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [7:0]       duty_cycle,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             period_err
);

  // Timeout counter can reach TIMEOUT itself, where it parks so the stuck
  // event fires exactly once per static stretch.
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  DUTY_MAX  = CNT_W'(255);
  localparam logic [CNT_W-1:0]  ERR_LO    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0]  ERR_HI    = CNT_W'(PERIOD + TOL);
  localparam logic [TCNT_W-1:0] TCNT_FIRE = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_PARK = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q, s_q, s_dly_q;
  logic rise, fall, any_edge;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
    end
  end

  assign rise     = s_q & ~s_dly_q;
  assign fall     = ~s_q & s_dly_q;
  assign any_edge = rise | fall;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0]   pc_q, pc_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [7:0]         duty_q, duty_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q, valid_d;
  logic               stuck_q, stuck_d;
  logic               err_q, err_d;

  // A static line overrides the FSM, except that an edge in the same cycle
  // takes the normal path.
  logic timeout_hit;
  assign timeout_hit = enable && !any_edge && (tcnt_q == TCNT_FIRE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_RISE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default assignment first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (!enable || timeout_hit) begin
      state_d = WAIT_RISE;
    end else begin
      unique case (state_q)
        WAIT_RISE: if (rise) state_d = HIGH;
        HIGH:      if (fall) state_d = LOW;
        LOW:       if (rise) state_d = HIGH;
        default:   state_d = WAIT_RISE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: counters and measurement outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    hc_d     = hc_q;
    pc_d     = pc_q;
    tcnt_d   = tcnt_q;
    duty_d   = duty_q;
    high_d   = high_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    err_d    = err_q;
    valid_d  = 1'b0;

    if (!enable) begin
      hc_d   = '0;
      pc_d   = '0;
      tcnt_d = '0;
    end else begin
      if (any_edge)                tcnt_d = '0;
      else if (tcnt_q != TCNT_PARK) tcnt_d = tcnt_q + TCNT_W'(1);

      if (timeout_hit) begin
        stuck_d  = 1'b1;
        duty_d   = s_q ? 8'hFF : 8'h00;
        high_d   = '0;
        period_d = '0;
        err_d    = 1'b0;
        valid_d  = 1'b1;
        hc_d     = '0;
        pc_d     = '0;
      end else begin
        unique case (state_q)
          WAIT_RISE: begin
            // First rise only arms: nothing to report without a full period.
            if (rise) begin
              hc_d = CNT_W'(1);
              pc_d = CNT_W'(1);
            end
          end
          HIGH: begin
            pc_d = sat_inc(pc_q);
            if (s_q) hc_d = sat_inc(hc_q);
          end
          LOW: begin
            if (rise) begin
              high_d   = hc_q;
              period_d = pc_q;
              duty_d   = (hc_q > DUTY_MAX) ? 8'hFF : hc_q[7:0];
              err_d    = (pc_q < ERR_LO) || (pc_q > ERR_HI);
              stuck_d  = 1'b0;
              valid_d  = 1'b1;
              // The rise cycle is the first cycle of the next period.
              hc_d     = CNT_W'(1);
              pc_d     = CNT_W'(1);
            end else begin
              pc_d = sat_inc(pc_q);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q     <= '0;
      pc_q     <= '0;
      tcnt_q   <= '0;
      duty_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      pc_q     <= pc_d;
      tcnt_q   <= tcnt_d;
      duty_q   <= duty_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      err_q    <= err_d;
    end
  end

  assign duty_cycle = duty_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;
  assign period_err = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Self-checking bench for pwm_capture. A timestamp-based model derives the
//   expected outputs from the edge times of the synchronized waveform; directed
//   scenarios add literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int PERIOD  = 256;
  localparam int TOL     = 4;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             pwm_in;
  logic [7:0]       duty_cycle;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             stuck;
  logic             period_err;

  pwm_capture #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .duty_cycle(duty_cycle),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .valid     (valid),
    .stuck     (stuck),
    .period_err(period_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                                 name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on edge timestamps of the input as seen after the
  // two-flop synchronizer (level at edge k is pwm_in sampled at edge k-2).
  // ---------------------------------------------------------------------------
  int   kcyc  = 0;   // posedge index
  bit   samp[$];     // pwm_in as sampled at each posedge (0 while in reset)
  bit   armed = 0;   // a rise has started a period that can be measured
  int   r_idx = 0;   // index of the rise that opened the current period
  int   f_idx = 0;   // index of the fall inside the current period
  int   z_idx = 0;   // last index at which the quiet-time count restarted

  logic [7:0]       e_duty   = '0;
  logic [CNT_W-1:0] e_high   = '0;
  logic [CNT_W-1:0] e_period = '0;
  logic             e_valid  = 1'b0;
  logic             e_stuck  = 1'b0;
  logic             e_err    = 1'b0;

  task automatic model_step();
    bit lv, lv_prev, rs, fl;
    int hi, per;
    kcyc++;
    e_valid = 1'b0;
    if (rst) begin
      samp.push_back(1'b0);
      e_duty = '0; e_high = '0; e_period = '0; e_stuck = 1'b0; e_err = 1'b0;
      armed = 0;
      z_idx = kcyc;
    end else begin
      samp.push_back(pwm_in);
      lv      = samp[samp.size()-3];
      lv_prev = samp[samp.size()-4];
      rs = lv & ~lv_prev;
      fl = ~lv & lv_prev;
      if (!enable) begin
        armed = 0;
        z_idx = kcyc;
      end else begin
        if (!(rs || fl) && (kcyc - z_idx == TIMEOUT)) begin
          e_stuck  = 1'b1;
          e_duty   = lv ? 8'd255 : 8'd0;
          e_high   = '0;
          e_period = '0;
          e_err    = 1'b0;
          e_valid  = 1'b1;
          armed    = 0;
        end else if (rs) begin
          if (armed) begin
            hi  = f_idx - r_idx;
            per = kcyc - r_idx;
            e_high   = CNT_W'(hi);
            e_period = CNT_W'(per);
            e_duty   = (hi > 255) ? 8'd255 : 8'(hi);
            e_err    = (per < PERIOD - TOL) || (per > PERIOD + TOL);
            e_stuck  = 1'b0;
            e_valid  = 1'b1;
          end
          armed = 1;
          r_idx = kcyc;
        end else if (fl) begin
          f_idx = kcyc;
        end
        if (rs || fl) z_idx = kcyc;
      end
    end
    while (samp.size() > 8) void'(samp.pop_front());
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // One comparison per cycle of every output against the model.
  int valid_seen = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("cycle_outputs",
            {duty_cycle, high_cnt, period_cnt, valid, stuck, period_err},
            {e_duty, e_high, e_period, e_valid, e_stuck, e_err});
      if (valid) valid_seen++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      pwm_in = 1'b1;
      wait_cyc(hi);
      pwm_in = 1'b0;
      wait_cyc(lo);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(5);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic check_outs(input string tag, input int duty, input int high,
                            input int period, input int stk, input int err);
    check({tag, "_duty"},   duty_cycle, duty);
    check({tag, "_high"},   high_cnt,   high);
    check({tag, "_period"}, period_cnt, period);
    check({tag, "_stuck"},  stuck,      stk);
    check({tag, "_err"},    period_err, err);
  endtask

  int v0;

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    @(posedge clk);
    #2;
    wait_cyc(4);
    check_outs("in_reset", 0, 0, 0, 0, 0);
    check("in_reset_valid", valid, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // 64/192 waveform: from the second period on, duty 64 and period 256.
    wave(64, 192, 4);
    check_outs("w64", 64, 64, 256, 0, 0);

    // Line held low after reset: one stuck report only.
    do_reset();
    v0 = valid_seen;
    wait_cyc(2200);
    check_outs("stuck_lo", 0, 0, 0, 1, 0);
    check("stuck_lo_valids", valid_seen - v0, 1);

    // Line held high, then a 128/256 waveform clears stuck.
    v0 = valid_seen;
    pwm_in = 1'b1;
    wait_cyc(1200);
    check_outs("stuck_hi", 255, 0, 0, 1, 0);
    check("stuck_hi_valids", valid_seen - v0, 1);
    wave(128, 128, 3);
    check_outs("w128", 128, 128, 256, 0, 0);

    // Generator duty 255: one low cycle per period is still a full period.
    wave(255, 1, 3);
    check_outs("w255", 255, 255, 256, 0, 0);

    // Short and slightly long periods.
    wave(100, 100, 3);
    check_outs("p200", 100, 100, 200, 0, 1);
    wave(129, 129, 3);
    check_outs("p258", 129, 129, 258, 0, 0);

    // Reset pulse mid-high: outputs clear at once.
    wave(128, 128, 2);
    pwm_in = 1'b1;
    wait_cyc(50);
    #1 rst = 1'b1;
    #1 check_outs("mid_rst", 0, 0, 0, 0, 0);
    check("mid_rst_valid", valid, 0);
    #103 rst = 1'b0;
    @(posedge clk);
    #2;
    wait_cyc(60);
    pwm_in = 1'b0;
    wait_cyc(60);
    // Disable mid-period, then a full period is needed before the next valid.
    enable = 1'b0;
    wait_cyc(20);
    enable = 1'b1;
    wait_cyc(10);
    v0 = valid_seen;
    wave(128, 128, 1);
    check("rearm_no_valid", valid_seen - v0, 0);
    pwm_in = 1'b1;
    wait_cyc(10);
    check("rearm_one_valid", valid_seen - v0, 1);
    check_outs("rearm", 128, 128, 256, 0, 0);

    // Randomized phase: mixed waveforms, static stretches and enable drops.
    for (int it = 0; it < 40; it++) begin
      int kind, per, hi;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        pwm_in = 1'($urandom_range(0, 1));
        wait_cyc(int'($urandom_range(1100, 1300)));
      end else if (kind == 1) begin
        enable = 1'b0;
        wait_cyc(int'($urandom_range(1, 30)));
        enable = 1'b1;
      end else begin
        per = int'($urandom_range(180, 330));
        hi  = int'($urandom_range(1, per - 1));
        wave(hi, per - hi, int'($urandom_range(1, 3)));
      end
    end
    wait_cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
